// File: rtl/app_mul_accumulate_pkg.sv
// Shared definitions for the approximate-multiplier datapath: product scalar
// type, accumulator FSM state encoding and 32-bit saturation limits.
package defines;

  typedef logic [31:0] scalar_t;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_RUN  = 2'd1,
    ACC_HOLD = 2'd2
  } app_acc_state_t;

  localparam scalar_t APP_ACC_SAT_MAX = 32'h7FFF_FFFF;
  localparam scalar_t APP_ACC_SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/app_mul_accumulate_if.sv
// Term-in / result-out handshake bundle for app_mul_accumulate.
// master drives terms and takes results; slave is the accumulator.
interface app_mul_accumulate_if #(
  parameter int COUNT_WIDTH = 8
);

  logic                   in_valid;
  logic                   in_ready;
  defines::scalar_t       in_product;
  logic                   in_sign;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  defines::scalar_t       out_result;
  logic [COUNT_WIDTH-1:0] out_count;
  logic                   out_overflow;

  modport master (
    output in_valid, in_product, in_sign, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_product, in_sign, in_last, out_ready,
    output in_ready, out_valid, out_result, out_count, out_overflow
  );

endinterface

// File: rtl/app_mul_accumulate_saturate.sv
// app_acc_saturate: reduces the wide signed packet sum to a 32-bit result.
// Build option APP_MUL_SATURATE_EN clamps to the signed 32-bit range and
// flags overflow; without it the low 32 bits pass through (wrap) and the
// overflow flag is tied low.
module app_acc_saturate
  import defines::*;
#(
  parameter int ACC_WIDTH = 40
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output scalar_t                     result,
  output logic                        overflow
);

`ifdef APP_MUL_SATURATE_EN
  logic signed [ACC_WIDTH-1:0] max_ext;
  logic signed [ACC_WIDTH-1:0] min_ext;

  assign max_ext = ACC_WIDTH'($signed(APP_ACC_SAT_MAX));
  assign min_ext = ACC_WIDTH'($signed(APP_ACC_SAT_MIN));

  // Clamp the sum to the signed 32-bit range and flag any clipping
  always_comb begin
    result   = sum[31:0];
    overflow = 1'b0;
    if (sum > max_ext) begin
      result   = APP_ACC_SAT_MAX;
      overflow = 1'b1;
    end else if (sum < min_ext) begin
      result   = APP_ACC_SAT_MIN;
      overflow = 1'b1;
    end
  end
`else
  logic unused_hi_bits;

  assign result         = sum[31:0];
  assign overflow       = 1'b0;
  assign unused_hi_bits = ^sum[ACC_WIDTH-1:32];
`endif

endmodule

// File: rtl/app_mul_accumulate.sv
// app_mul_accumulate: folds a packet of signed product terms from the
// approximate multiplier into one 32-bit dot-product result with a saturating
// term count. Optional clamping of the result: define APP_MUL_SATURATE_EN.
module app_mul_accumulate
  import defines::*;
#(
  parameter int ACC_WIDTH   = 40,
  parameter int COUNT_WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  app_mul_accumulate_if.slave bus
);

  if (ACC_WIDTH < 34) begin : g_bad_width
    $error("app_mul_accumulate: ACC_WIDTH must be at least 34");
  end

  app_acc_state_t              state_p0;
  app_acc_state_t              state_nxt;
  logic                        rdy;
  logic                        accept;
  logic                        close;
  logic signed [ACC_WIDTH-1:0] term;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] acc_p1;
  logic [COUNT_WIDTH-1:0]      count_nxt;
  logic [COUNT_WIDTH-1:0]      count_p1;
  scalar_t                     sat_result;
  logic                        sat_ovf;
  logic                        vld_p1;
  scalar_t                     result_p1;
  logic [COUNT_WIDTH-1:0]      out_count_p1;
  logic                        ovf_p1;

  // Term counter increment that sticks at all-ones
  function automatic logic [COUNT_WIDTH-1:0] count_sat_inc(
    input logic [COUNT_WIDTH-1:0] c
  );
    return (&c) ? c : c + COUNT_WIDTH'(1);
  endfunction

  // Advance the packet FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_p0 <= ACC_IDLE;
    else        state_p0 <= state_nxt;
  end

  // Next state from the accepted term and the result handshake
  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      ACC_IDLE: if (accept)            state_nxt = bus.in_last ? ACC_HOLD : ACC_RUN;
      ACC_RUN:  if (accept && bus.in_last) state_nxt = ACC_HOLD;
      ACC_HOLD: if (bus.out_ready)     state_nxt = ACC_IDLE;
      default:                         state_nxt = ACC_IDLE;
    endcase
  end

  // Handshake outputs depend on state only; no term enters during HOLD
  always_comb begin
    rdy    = (state_p0 != ACC_HOLD);
    accept = bus.in_valid && rdy;
    close  = accept && bus.in_last;
  end

  // Signed term, running sum and next count; IDLE starts a fresh packet
  always_comb begin
    term = $signed({{(ACC_WIDTH-32){1'b0}}, bus.in_product});
    if (bus.in_sign) term = -term;
    if (state_p0 == ACC_IDLE) begin
      sum       = term;
      count_nxt = COUNT_WIDTH'(1);
    end else begin
      sum       = acc_p1 + term;
      count_nxt = count_sat_inc(count_p1);
    end
  end

  app_acc_saturate #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat (
    .sum      (sum),
    .result   (sat_result),
    .overflow (sat_ovf)
  );

  // ---- stage p1: accumulator and count capture on every accepted term ----
  // Capture the running sum and count whenever a term is taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_p1   <= '0;
      count_p1 <= '0;
    end else if (accept) begin
      acc_p1   <= sum;
      count_p1 <= count_nxt;
    end
  end

  // Register the packet result on the closing term; hold it until taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1       <= 1'b0;
      result_p1    <= '0;
      out_count_p1 <= '0;
      ovf_p1       <= 1'b0;
    end else if (close) begin
      vld_p1       <= 1'b1;
      result_p1    <= sat_result;
      out_count_p1 <= count_nxt;
      ovf_p1       <= sat_ovf;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1       <= 1'b0;
    end
  end

  assign bus.in_ready     = rdy;
  assign bus.out_valid    = vld_p1;
  assign bus.out_result   = result_p1;
  assign bus.out_count    = out_count_p1;
  assign bus.out_overflow = ovf_p1;

endmodule

// File: tb/tb_app_mul_accumulate.sv
// Directed bench for app_mul_accumulate with hand-computed packet results.
module tb_app_mul_accumulate;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  app_mul_accumulate_if #(.COUNT_WIDTH(8)) bus ();

  app_mul_accumulate #(
    .ACC_WIDTH   (40),
    .COUNT_WIDTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one term at a negedge and return at the negedge after acceptance
  task automatic send_term(input logic [31:0] p, input logic s, input logic l);
    bit done = 0;
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    bus.in_sign    = s;
    bus.in_last    = l;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.in_ready) done = 1;
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Check a pending result, then take it and confirm the input reopens
  task automatic expect_result(input string tag, input logic [31:0] r,
                               input logic [7:0] c, input logic o);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_result"}, 64'(bus.out_result), 64'(r));
    check({tag, "_count"}, 64'(bus.out_count), 64'(c));
    check({tag, "_ovf"}, 64'(bus.out_overflow), 64'(o));
    check({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_taken"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_reopen"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_sign    = 1'b0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    idle_cycles(3);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.out_result), 64'd0);
    check("rst_count", 64'(bus.out_count), 64'd0);
    check("rst_ovf", 64'(bus.out_overflow), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b1;
    idle_cycles(2);

    // single-term packet; in_ready stays low while unclaimed
    send_term(32'd100, 1'b0, 1'b1);
    idle_cycles(2);
    check("single_hold_busy", 64'(bus.in_ready), 64'd0);
    expect_result("single", 32'd100, 8'd1, 1'b0);

    // mixed-sign packet held for five cycles
    send_term(32'd1000, 1'b0, 1'b0);
    send_term(32'd300, 1'b1, 1'b0);
    send_term(32'd50, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle_cycles(1);
      check("stable_result", 64'(bus.out_result), 64'd750);
      check("stable_count", 64'(bus.out_count), 64'd3);
    end
    expect_result("mixed", 32'd750, 8'd3, 1'b0);

    // two maximal products: sum 0x1_FFFF_FFFE
    send_term(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_term(32'hFFFF_FFFF, 1'b0, 1'b1);
`ifdef APP_MUL_SATURATE_EN
    expect_result("big", 32'h7FFF_FFFF, 8'd2, 1'b1);
`else
    expect_result("big", 32'hFFFF_FFFE, 8'd2, 1'b0);
`endif

    // negative single term
    send_term(32'd10, 1'b1, 1'b1);
    expect_result("neg", 32'hFFFF_FFF6, 8'd1, 1'b0);

    // 300 terms of +1: count saturates, sum does not
    for (int i = 0; i < 300; i++) send_term(32'd1, 1'b0, (i == 299));
    expect_result("long", 32'd300, 8'd255, 1'b0);

    // gaps inside a packet, then reset mid-packet
    send_term(32'd3, 1'b0, 1'b0);
    idle_cycles(2);
    send_term(32'd4, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_result", 64'(bus.out_result), 64'd0);
    check("mid_rst_count", 64'(bus.out_count), 64'd0);
    idle_cycles(1);
    reset = 1'b1;
    idle_cycles(1);
    send_term(32'd7, 1'b0, 1'b1);
    expect_result("post_rst", 32'd7, 8'd1, 1'b0);

    // negative zero contributes nothing
    send_term(32'd0, 1'b1, 1'b0);
    send_term(32'd5, 1'b0, 1'b1);
    expect_result("negzero", 32'd5, 8'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
